// File: rtl/app_ch_readout.sv
// Readout back-end for one APP analog channel: edge timestamping, acquisition window
// control, one ADC conversion per captured event and a valid/ready record stream.
module app_ch_readout #(
  parameter int TS_W        = 12,
  parameter int ADC_W       = 10,
  parameter int MAX_EV      = 8,
  parameter int TIMEOUT_CYC = 64,
  parameter int TOPULSE_CYC = 2,
  parameter int REARM_CYC   = 4
) (
  input  logic              clk,
  input  logic              rst_init_n,
  input  logic              enable,
  input  logic [MAX_EV-1:0] vp_front,
  input  logic [MAX_EV-1:0] vp_back,
  input  logic [3:0]        count_in,
  output logic              timeout,
  output logic              read_en,
  output logic              rst_init,
  output logic              adc_req,
  output logic [2:0]        adc_sel,
  input  logic              adc_ack,
  input  logic [ADC_W-1:0]  adc_data,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [2:0]        ev_index,
  output logic [TS_W-1:0]   ev_ts_front,
  output logic [TS_W-1:0]   ev_ts_back,
  output logic [ADC_W-1:0]  ev_amp,
  output logic              ev_last,
  output logic              busy,
  output logic              err_mismatch
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  localparam int PH_W   = 8;

  typedef enum logic [2:0] {
    S_REARM, S_ARMED, S_ACQ, S_TOUT, S_READ, S_ADC_WAIT, S_EMIT
  } state_t;

  state_t state, state_n;

  logic [MAX_EV-1:0] fr_s1, fr_s2, fr_s3, fr_edge;
  logic [MAX_EV-1:0] bk_s1, bk_s2, bk_s3, bk_edge;
  logic [3:0]        cnt_s1, cnt_s2;
  logic [TS_W-1:0]   ts_cnt;
  logic [TS_W-1:0]   ts_front_q [MAX_EV];
  logic [TS_W-1:0]   ts_back_q  [MAX_EV];
  logic [MAX_EV-1:0] front_seen, back_seen;
  logic [PH_W-1:0]   phase_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [2:0]        idx;
  logic [3:0]        n_ev, n_ev_calc, pop_calc;
  logic [ADC_W-1:0]  amp_q;
  logic              err_q, busy_q;
  logic              any_edge, capture_en, last_c;

  assign any_edge   = (|fr_edge) || (|bk_edge);
  assign capture_en = (state == S_ACQ) || (state == S_ARMED && enable && (|fr_edge));
  assign last_c     = ({1'b0, idx} == n_ev - 4'd1);

  // Window size is set by the highest captured front, not by how many fronts arrived.
  always_comb begin
    n_ev_calc = '0;
    pop_calc  = '0;
    for (int i = 0; i < MAX_EV; i++) begin
      if (front_seen[i]) begin
        n_ev_calc = 4'(i + 1);
        pop_calc  = pop_calc + 4'd1;
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_REARM:    if (phase_cnt == PH_W'(REARM_CYC - 1)) state_n = S_ARMED;
      S_ARMED:    if (enable && (|fr_edge)) state_n = S_ACQ;
      S_ACQ: begin
        if (back_seen[MAX_EV-1]) state_n = S_READ;
        else if (!any_edge && idle_cnt == IDLE_W'(TIMEOUT_CYC - 1)) state_n = S_TOUT;
      end
      S_TOUT:     if (phase_cnt == PH_W'(TOPULSE_CYC - 1)) state_n = S_READ;
      S_READ:     state_n = (n_ev_calc == 4'd0) ? S_REARM : S_ADC_WAIT;
      S_ADC_WAIT: if (adc_ack) state_n = S_EMIT;
      S_EMIT:     if (ev_ready) state_n = last_c ? S_REARM : S_ADC_WAIT;
      default:    state_n = S_REARM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_init_n) begin
      state      <= S_REARM;
      {fr_s1, fr_s2, fr_s3, fr_edge} <= '0;
      {bk_s1, bk_s2, bk_s3, bk_edge} <= '0;
      cnt_s1     <= '0;
      cnt_s2     <= '0;
      ts_cnt     <= '0;
      front_seen <= '0;
      back_seen  <= '0;
      phase_cnt  <= '0;
      idle_cnt   <= '0;
      idx        <= '0;
      n_ev       <= '0;
      amp_q      <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      for (int i = 0; i < MAX_EV; i++) begin
        ts_front_q[i] <= '0;
        ts_back_q[i]  <= '0;
      end
    end else begin
      state   <= state_n;
      ts_cnt  <= ts_cnt + TS_W'(1);
      busy_q  <= (state_n != S_ARMED);
      // Edge flag is registered so a stamp lands 3 cycles after the input is sampled.
      fr_s1   <= vp_front;
      fr_s2   <= fr_s1;
      fr_s3   <= fr_s2;
      fr_edge <= fr_s2 & ~fr_s3;
      bk_s1   <= vp_back;
      bk_s2   <= bk_s1;
      bk_s3   <= bk_s2;
      bk_edge <= bk_s2 & ~bk_s3;
      cnt_s1  <= count_in;
      cnt_s2  <= cnt_s1;
      phase_cnt <= (state_n != state) ? '0 : phase_cnt + PH_W'(1);
      idle_cnt  <= (state == S_ACQ && !any_edge) ? idle_cnt + IDLE_W'(1) : '0;

      if (state == S_REARM) begin
        front_seen <= '0;
        back_seen  <= '0;
        idx        <= '0;
        n_ev       <= '0;
      end else if (capture_en) begin
        for (int i = 0; i < MAX_EV; i++) begin
          if (fr_edge[i] && !front_seen[i]) begin
            front_seen[i] <= 1'b1;
            ts_front_q[i] <= ts_cnt;
          end
          if (bk_edge[i] && !back_seen[i]) begin
            back_seen[i] <= 1'b1;
            ts_back_q[i] <= ts_cnt;
          end
        end
      end

      case (state)
        S_READ: begin
          n_ev <= n_ev_calc;
          idx  <= '0;
          if (cnt_s2 != pop_calc) err_q <= 1'b1;
        end
        S_ADC_WAIT: if (adc_ack) amp_q <= adc_data;
        S_EMIT:     if (ev_ready && !last_c) idx <= idx + 3'd1;
        default: ;
      endcase
    end
  end

  // Record stream: a record moves on a cycle with ev_valid && ev_ready; while ev_valid
  // is high without ev_ready every ev_* field holds, and fields read 0 when not valid.
  assign ev_valid     = (state == S_EMIT);
  assign ev_index     = ev_valid ? idx : 3'd0;
  assign ev_ts_front  = !ev_valid ? '0 : (front_seen[idx] ? ts_front_q[idx] : '1);
  assign ev_ts_back   = !ev_valid ? '0 : (back_seen[idx] ? ts_back_q[idx] : '1);
  assign ev_amp       = ev_valid ? amp_q : '0;
  assign ev_last      = ev_valid && last_c;
  assign timeout      = (state == S_TOUT);
  assign read_en      = (state == S_READ) || (state == S_ADC_WAIT) || (state == S_EMIT);
  assign rst_init     = (state == S_REARM);
  assign adc_req      = (state == S_ADC_WAIT);
  assign adc_sel      = adc_req ? idx : 3'd0;
  assign busy         = busy_q;
  assign err_mismatch = err_q;

endmodule

// File: tb/tb_app_ch_readout.sv
// Bench for app_ch_readout: directed scenarios plus randomized windows, checked against
// a window-level event model (first edge per index, stamp = drive cycle + 3).
`timescale 1ns/1ps
module tb_app_ch_readout;
  localparam int TS_W = 12, ADC_W = 10, MAX_EV = 8;
  localparam int TIMEOUT_CYC = 64, TOPULSE_CYC = 2, REARM_CYC = 4;
  localparam int REC_W = 3 + 2 * TS_W + ADC_W + 1;
  localparam logic [TS_W-1:0] TS_NONE = '1;

  logic clk = 1'b0;
  logic rst_init_n = 1'b0, enable = 1'b0, adc_ack = 1'b0, ev_ready = 1'b0;
  logic [MAX_EV-1:0] vp_front = '0, vp_back = '0;
  logic [3:0] count_in = '0;
  logic [ADC_W-1:0] adc_data = '0;
  logic timeout, read_en, rst_init, adc_req, ev_valid, ev_last, busy, err_mismatch;
  logic [2:0] adc_sel, ev_index;
  logic [TS_W-1:0] ev_ts_front, ev_ts_back;
  logic [ADC_W-1:0] ev_amp;

  app_ch_readout dut (
    .clk(clk), .rst_init_n(rst_init_n), .enable(enable), .vp_front(vp_front),
    .vp_back(vp_back), .count_in(count_in), .timeout(timeout), .read_en(read_en),
    .rst_init(rst_init), .adc_req(adc_req), .adc_sel(adc_sel), .adc_ack(adc_ack),
    .adc_data(adc_data), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_index(ev_index),
    .ev_ts_front(ev_ts_front), .ev_ts_back(ev_ts_back), .ev_amp(ev_amp),
    .ev_last(ev_last), .busy(busy), .err_mismatch(err_mismatch)
  );

  // Clock / reset-relative time base
  always #5 clk = ~clk;

  logic [TS_W-1:0] tb_ts;
  always @(posedge clk) begin
    if (!rst_init_n) tb_ts <= '0;
    else tb_ts <= tb_ts + 1'b1;
  end

  int to_pulses = 0, to_w = 0, to_last_w = 0;
  logic [TS_W-1:0] to_start = '0;
  logic to_prev = 1'b0;
  always @(negedge clk) begin
    if (timeout && !to_prev) begin
      to_pulses <= to_pulses + 1;
      to_start  <= tb_ts;
    end
    if (timeout) to_w <= to_w + 1;
    else if (to_prev) begin
      to_last_w <= to_w;
      to_w      <= 0;
    end
    to_prev <= timeout;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: observed no end of run, expected $finish");
    $fatal(1, "watchdog expired");
  end

  // Reference model and scoreboard
  logic [TS_W-1:0]   m_front [MAX_EV];
  logic [TS_W-1:0]   m_back  [MAX_EV];
  logic [MAX_EV-1:0] m_fseen, m_bseen;
  bit                m_acq;
  bit                err_exp = 1'b0;
  logic [TS_W-1:0]   last_stamp;
  logic [REC_W-1:0]  exp_q[$];
  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [REC_W-1:0] cur_rec();
    return {ev_index, ev_ts_front, ev_ts_back, ev_amp, ev_last};
  endfunction

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic win_clear();
    m_fseen = '0;
    m_bseen = '0;
    m_acq   = 1'b0;
  endtask

  // Drivers
  task automatic pulse(input bit is_back, input int i);
    logic [TS_W-1:0] st;
    st = tb_ts + TS_W'(3);
    if (enable && !is_back) m_acq = 1'b1;
    if (m_acq) begin
      if (is_back) begin
        if (!m_bseen[i]) begin m_bseen[i] = 1'b1; m_back[i] = st; end
      end else begin
        if (!m_fseen[i]) begin m_fseen[i] = 1'b1; m_front[i] = st; end
      end
    end
    last_stamp = st;
    if (is_back) vp_back[i] = 1'b1; else vp_front[i] = 1'b1;
    gap(2);
    if (is_back) vp_back[i] = 1'b0; else vp_front[i] = 1'b0;
  endtask

  task automatic run_readout(input int bp_rec, input int bp_len);
    int n_ev, pop, n, bad;
    logic [ADC_W-1:0] d;
    logic [REC_W-1:0] exp_rec;
    n_ev = 0;
    pop  = 0;
    for (int i = 0; i < MAX_EV; i++) if (m_fseen[i]) begin n_ev = i + 1; pop++; end
    if (int'(count_in) != pop) err_exp = 1'b1;
    for (int k = 0; k < n_ev; k++) begin
      n = 0;
      while (adc_req !== 1'b1 && n < 400) begin @(negedge clk); n++; end
      chk("adc_req_seen", adc_req, 1);
      chk("adc_sel", adc_sel, k);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      d = ADC_W'($urandom_range(0, 1023));
      adc_ack = 1'b1;
      adc_data = d;
      @(negedge clk);
      adc_ack = 1'b0;
      adc_data = ADC_W'($urandom);
      chk("adc_req_drop", adc_req, 0);
      exp_rec = {3'(k), m_fseen[k] ? m_front[k] : TS_NONE,
                 m_bseen[k] ? m_back[k] : TS_NONE, d, 1'(k == n_ev - 1)};
      exp_q.push_back(exp_rec);
      n = 0;
      while (ev_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
      chk("ev_valid", ev_valid, 1);
      if (k == bp_rec) begin
        bad = 0;
        repeat (bp_len) begin
          if (ev_valid !== 1'b1 || adc_req !== 1'b0 || cur_rec() !== exp_rec) bad++;
          @(negedge clk);
        end
        chk("bp_stable", bad, 0);
      end
      ev_ready = 1'b1;
      chk("record", cur_rec(), exp_q.pop_front());
      @(negedge clk);
      ev_ready = 1'b0;
      chk("valid_drop", ev_valid, 0);
    end
  endtask

  initial begin
    int n, p0, bad, npul;
    int plist[$];
    enable = 1'b0;
    win_clear();

    // Reset state
    rst_init_n = 1'b0;
    gap(2);
    chk("rst_rst_init", rst_init, 1);
    chk("rst_busy", busy, 0);
    chk("rst_read_en", read_en, 0);
    chk("rst_adc_req", adc_req, 0);
    chk("rst_ev_valid", ev_valid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_err", err_mismatch, 0);
    rst_init_n = 1'b1;
    enable = 1'b1;

    // Single event: front at ts 100, back at ts 140
    count_in = 4'd1;
    win_clear();
    n = 0;
    while (tb_ts != TS_W'(100) && n < 5000) begin @(negedge clk); n++; end
    pulse(0, 0);
    while (tb_ts != TS_W'(140) && n < 5000) begin @(negedge clk); n++; end
    pulse(1, 0);
    p0 = to_pulses;
    run_readout(-1, 0);
    chk("single_to_count", to_pulses - p0, 1);
    chk("single_to_width", to_last_w, TOPULSE_CYC);
    // 64 idle cycles follow the detect cycle, so the pulse starts one cycle later
    chk("single_to_delay", 12'(to_start - last_stamp), TIMEOUT_CYC + 1);
    n = 0;
    while (rst_init === 1'b1 && n < 20) begin n++; @(negedge clk); end
    chk("rearm_width", n, REARM_CYC);
    chk("armed_busy", busy, 0);

    // Full window with backpressure on record 2
    gap(4);
    win_clear();
    count_in = 4'd8;
    p0 = to_pulses;
    for (int i = 0; i < MAX_EV; i++) begin
      pulse(0, i);
      gap($urandom_range(2, 10));
      pulse(1, i);
      if (i != MAX_EV - 1) gap($urandom_range(2, 10));
    end
    run_readout(2, 20);
    chk("full_no_timeout", to_pulses - p0, 0);
    chk("full_err", err_mismatch, 0);

    // Missing back edge and a repeated front on index 0
    gap(8);
    win_clear();
    count_in = 4'd1;
    pulse(0, 0);
    gap(10);
    pulse(0, 0);
    run_readout(-1, 0);

    // Randomized windows, back[7] withheld so each window times out
    for (int w = 0; w < 5; w++) begin
      gap(8);
      win_clear();
      count_in = 4'($urandom_range(0, 8));
      plist.delete();
      for (int i = 0; i < MAX_EV; i++) begin
        if ($urandom_range(0, 1) == 1) plist.push_back(i);
        if ($urandom_range(0, 2) != 0 && i != MAX_EV - 1) plist.push_back(8 + i);
        if ($urandom_range(0, 5) == 0) plist.push_back(i);
      end
      plist.push_back(int'($urandom_range(0, MAX_EV - 1)));
      npul = plist.size();
      for (int i = npul - 1; i > 0; i--) begin
        int j, t;
        j = int'($urandom_range(0, i));
        t = plist[i]; plist[i] = plist[j]; plist[j] = t;
      end
      p0 = to_pulses;
      foreach (plist[i]) begin
        pulse(plist[i] >= 8, plist[i] % 8);
        gap($urandom_range(2, 20));
      end
      run_readout(int'($urandom_range(0, 7)), int'($urandom_range(1, 6)));
      chk("rnd_timeout", to_pulses - p0, 1);
      chk("rnd_err", err_mismatch, err_exp);
    end

    // Count mismatch, then enable low in ARMED
    gap(8);
    win_clear();
    count_in = 4'd3;
    pulse(0, 1);
    gap(5);
    pulse(0, 4);
    run_readout(-1, 0);
    chk("mm_err", err_mismatch, 1);
    gap(12);
    chk("mm_sticky", err_mismatch, 1);
    enable = 1'b0;
    win_clear();
    pulse(0, 2);
    bad = 0;
    repeat (80) begin
      if (busy !== 1'b0 || read_en !== 1'b0 || timeout !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("disabled_idle", bad, 0);
    enable = 1'b1;

    // Reset while a conversion is pending; the late ack must not yield a record
    win_clear();
    count_in = 4'd1;
    pulse(0, 0);
    n = 0;
    while (adc_req !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    chk("mid_adc_req", adc_req, 1);
    rst_init_n = 1'b0;
    @(negedge clk);
    err_exp = 1'b0;
    chk("mid_adc_req0", adc_req, 0);
    chk("mid_read_en0", read_en, 0);
    chk("mid_rst_init", rst_init, 1);
    chk("mid_err_clear", err_mismatch, err_exp);
    rst_init_n = 1'b1;
    adc_ack = 1'b1;
    adc_data = ADC_W'(10'h2aa);
    @(negedge clk);
    adc_ack = 1'b0;
    bad = 0;
    repeat (30) begin
      if (ev_valid !== 1'b0 || adc_req !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("late_ack_no_record", bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/app_ch_readout.md
Name: app_ch_readout

Overview:
- Digital back-end for one APP analog channel.
- Consumes the channel's VP_front/VP_back TAC pulses and count, and timestamps each event's rising and falling edges against a coarse counter.
- Drives the channel's timeout, read_en and rst_init.
- Sequences one ADC conversion per captured event, then emits one record per event on a valid/ready stream and re-arms the channel.

Parameters:
TS_W, 12, coarse timestamp counter width
ADC_W, 10, ADC result width
MAX_EV, 8, events per window (ping/pong depth); VP bus width
TIMEOUT_CYC, 64, idle cycles after the last detected edge before timeout
TOPULSE_CYC, 2, width of the timeout pulse
REARM_CYC, 4, width of the rst_init pulse

Ports:
clk  in  1  system clock
rst_init_n  in  1  synchronous active-low reset
enable  in  1  permits leaving ARMED
vp_front  in  MAX_EV  channel TAC front pulses (async)
vp_back  in  MAX_EV  channel TAC back pulses (async)
count_in  in  4  channel event count (async)
timeout  out  1  to channel timeout input
read_en  out  1  to channel read_en
rst_init  out  1  to channel rst_init
adc_req  out  1  conversion request
adc_sel  out  3  sample index to convert
adc_ack  in  1  conversion done; adc_data valid this cycle
adc_data  in  ADC_W  ADC result
ev_valid  out  1  record valid
ev_ready  in  1  downstream accept
ev_index  out  3  event index
ev_ts_front  out  TS_W  front timestamp
ev_ts_back  out  TS_W  back timestamp; all-ones if no back edge was seen
ev_amp  out  ADC_W  amplitude
ev_last  out  1  last record of the window
busy  out  1  high in every state except ARMED
err_mismatch  out  1  sticky: synchronized count_in differs from the number of captured fronts at readout

Behaviour:
- Reset (rst_init_n low at a clk edge):
  - All outputs 0 except rst_init=1.
  - All flags and counters cleared; ts_cnt=0.
  - State is REARM with its counter at 0.
  - A mid-operation reset aborts any handshake immediately. A pending adc_ack is ignored.
- ts_cnt: free-running, increments every cycle, wraps modulo 2^TS_W. No wrap correction.
- Input synchronization:
  - vp_front, vp_back and count_in each pass through a 2-flop synchronizer.
  - A rising edge is detected by comparing the synchronizer output with a third flop.
  - A detected edge latches the ts_cnt value of the detect cycle. Fixed latency: 3 clk.
- Capture rules:
  - Only the first rising edge per index per window is captured (front_seen[i], back_seen[i]).
  - Later edges on the same index are ignored.
  - A back edge is captured even if its front was not seen.
  - Edges are captured only in ARMED and ACQ.
- States:
  - REARM:
    - rst_init=1 for REARM_CYC cycles.
    - Clears all flags, n_ev, the timeout counter and the event index.
    - Then goes to ARMED.
  - ARMED:
    - busy=0.
    - If enable=1 and a front edge is detected, capture it and go to ACQ.
    - If enable=0, stay in ARMED; edges are ignored.
  - ACQ:
    - The idle counter clears on any detected edge and otherwise increments.
    - If back_seen[MAX_EV-1]=1, go to READ with no timeout pulse.
    - Otherwise, when the idle counter reaches TIMEOUT_CYC, go to TOUT.
    - enable is ignored once in ACQ.
  - TOUT:
    - timeout=1 for TOPULSE_CYC cycles, then go to READ.
    - Edges arriving during TOUT are not captured.
  - READ entry:
    - n_ev = index of highest front_seen + 1.
    - If the synchronized count_in != popcount(front_seen), set err_mismatch.
    - If n_ev=0, go to REARM.
    - idx=0; read_en=1 through READ, ADC_WAIT and EMIT.
  - ADC_WAIT:
    - adc_req=1 with adc_sel=idx, held until a cycle with adc_ack=1.
    - Latch adc_data on that cycle.
    - adc_req is 0 from the next cycle; go to EMIT.
    - adc_ack seen while adc_req=0 is ignored.
  - EMIT:
    - ev_valid=1; all ev_* fields stay stable until ev_ready=1.
    - ev_last=(idx==n_ev-1).
    - On transfer, ev_valid=0 next cycle.
    - If last, go to REARM (read_en drops). Else idx+1 and go to ADC_WAIT.
    - Indices with front_seen=0 below n_ev are still emitted, with ev_ts_front=all-ones.
- err_mismatch clears only on reset.

Test Plan:
- Single event: front pulse at ts=100, back at ts=140, count_in=1, enable=1 -> timeout pulse 2 cycles, TIMEOUT_CYC after the back detect. adc_req with sel=0; ack with data=0x155 -> one record: index 0, ts_front=103, ts_back=143, amp=0x155, last=1. Then rst_init high for 4 cycles.
- Full window: 8 front/back pairs -> no timeout pulse. 8 records, indices 0..7, ev_last only on index 7. err_mismatch=0 with count_in=8.
- Backpressure: hold ev_ready=0 for 20 cycles on record 2 -> ev_valid and fields stable, and no adc_req is issued until the transfer.
- Missing back: front[0] only -> after timeout, ts_back=0xFFF. Second pulse on vp_front[0] inside the window -> ignored, and ts_front keeps the first value.
- Mismatch plus enable: count_in=3 with 2 fronts -> err_mismatch=1, sticky across the rearm. With enable=0 in ARMED, a front pulse -> no capture, busy=0.
- Reset mid-READ: assert rst_init_n=0 while adc_req=1 -> next cycle adc_req=0, read_en=0, rst_init=1. A late adc_ack produces no record.
